ld_point_add_seq: RTL
=====================

# ld_point_add_seq

Sequential, parametrised Lopez-Dahab mixed point adder over GF(2^M). It adds a projective point P0 = (X0:Y0:Z0) and an affine point P1 = (X1, Y1) using one shared field multiplier, sequenced by an FSM. It uses valid/ready handshakes on input and output. It replaces the fixed 4-bit combinational adder in the ECC datapath and feeds the scalar-multiply controller.

## Interface
- `M`, 4, field width in bits.
- `POLY`, 4'b0011, low M bits of the reduction polynomial (x^4+x+1).
- `CURVE_A`, 4'b0100, curve coefficient a, M bits.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand set valid.
- `in_ready` out 1: block can accept operands.
- `x0`, `y0`, `z0`, `x1`, `y1` in M each: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `x2`, `y2`, `z2` out M each: projective result.
- `dbl_req` out 1: P0 == P1, so the result is invalid and the point must be doubled instead.

## Operation
- FSM states are IDLE, CALC and DONE.
- `in_ready` = (state == IDLE) && !rst.
- **Accept.** A transfer happens when `in_valid && in_ready`. On that edge, all operands are registered and the FSM moves to CALC with step = 0.
- **Infinity bypass.** If the registered z0 == 0, P0 is the point at infinity. CALC runs one cycle and loads x2 = x1, y2 = y1, z2 = 1, dbl_req = 0.
- **Normal path.** Otherwise there are 14 multiply steps S0..S13. Each step issues one product through the shared multiplier. Additions are XOR and are fused into the step that consumes them.
  - S0: T = z0²
  - S1: A = y1·T ⊕ y0
  - S2: B = x1·z0 ⊕ x0
  - S3: C = z0·B
  - S4: U = B²
  - S5: V = a·T ⊕ C
  - S6: D = U·V
  - S7: Z2 = C²
  - S8: E = A·C
  - S9: X2 = A² ⊕ D ⊕ E
  - S10: F = x1·Z2 ⊕ X2
  - S11: G = y1·Z2 ⊕ X2
  - S12: W = E·F
  - S13: Y2 = Z2·G ⊕ W
- **Doubling detect.** At the end of S2, if A == 0 and B == 0, the step sequence aborts. The block moves to DONE with dbl_req = 1 and x2/y2/z2 = 0.
- **DONE.** `out_valid` = 1. Outputs and dbl_req hold stable until `out_valid && out_ready`; the FSM then returns to IDLE.
- Squarings use the general multiplier with both inputs equal.
- All arithmetic is modulo POLY and exactly M bits wide.
- **Reset.** `rst` high forces state = IDLE. It clears out_valid, dbl_req, x2, y2, z2 and all internal registers to 0. `in_ready` = 0 while rst is high.
- **Reset mid-CALC or mid-DONE.** The operation is aborted with no result emitted. In-flight data is discarded.

## Timing
- Accept happens on edge k.
- Normal path with the default multiplier: one step per cycle. `out_valid` rises after edge k+14.
- Infinity bypass: `out_valid` rises after edge k+1.
- Doubling abort: `out_valid` rises after edge k+3.
- The next input cannot be accepted until the cycle after the output transfer. There is no overlap, so throughput is at most one operation per (latency + 1) cycles.
- The output path is registered.
- `out_ready` may be held low indefinitely. While it is low, outputs must not change.

## Configuration
- `LD_PADD_SERIAL_MUL_EN` defined: the multiplier is bit-serial, MSB first, M cycles per product.
  - Each step S0..S13 takes M cycles.
  - Normal latency is 14·M cycles (56 at M = 4).
  - The bypass and abort paths scale the same way.
- `LD_PADD_SERIAL_MUL_EN` undefined: the multiplier is single-cycle combinational, and latencies are as given under Timing.

## Structure
- Package `ld_gf2m_pkg` holds:
  - the state enum (IDLE/CALC/DONE)
  - the step enum S0..S13 plus `NUM_STEPS = 14`
  - default `POLY` and `CURVE_A` constants for M = 4
- Sub-module `gf2m_mul` (params M, POLY) implements both variants. The serial variant has start/done ports; the combinational variant ties done high.
- The top level contains the FSM, the step counter, an operand mux and the intermediate register file (T, A, B, C, U/V/D, E, F, G, W, X2, Y2, Z2).

## Test plan
All cases use M = 4, POLY = 0011 and a = 0100.
- **Full add.** (x0, y0, z0, x1, y1) = (0, 0, 2, 1, 1) -> (x2, y2, z2) = (F, 0, 3), dbl_req = 0. `out_valid` asserts 14 cycles after accept (56 cycles with the serial macro).
- **Simple add.** (0, 0, 1, 1, 0) -> (5, 5, 1).
- **Infinity.** z0 = 0, x1 = 3, y1 = 5 -> (3, 5, 1) after 1 cycle.
- **Doubling.** (1, 1, 1, 1, 1) -> dbl_req = 1, outputs 0, `out_valid` after 3 cycles.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles after `out_valid`. Outputs must stay stable and `in_ready` must stay 0. Then pulse `out_ready`: `in_ready` = 1 the next cycle, and back-to-back operations complete correctly.
- **Reset mid-operation.** Assert `rst` for 1 cycle during S6. Expect out_valid = 0, all outputs 0, `in_ready` = 1 after release, and a subsequent add producing the correct result.

Source files
------------

// File: rtl/ld_gf2m_pkg.sv
// Shared types and constants for the Lopez-Dahab mixed point adder over GF(2^M).
// Holds the controller state enum, the multiply-step enum and default field
// constants for M = 4 (x^4 + x + 1, a = 4).
package ld_gf2m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        S0  = 4'd0,
        S1  = 4'd1,
        S2  = 4'd2,
        S3  = 4'd3,
        S4  = 4'd4,
        S5  = 4'd5,
        S6  = 4'd6,
        S7  = 4'd7,
        S8  = 4'd8,
        S9  = 4'd9,
        S10 = 4'd10,
        S11 = 4'd11,
        S12 = 4'd12,
        S13 = 4'd13
    } step_t;

    localparam int         NUM_STEPS   = 14;
    localparam int         M_DEF       = 4;
    localparam logic [3:0] POLY_DEF    = 4'b0011;
    localparam logic [3:0] CURVE_A_DEF = 4'b0100;

endpackage

// File: rtl/gf2m_mul.sv
// GF(2^M) multiplier, product reduced modulo x^M + POLY.
// Build option LD_PADD_SERIAL_MUL_EN: bit-serial MSB-first, M cycles per product.
// Without it the product is combinational and done is tied high.
// start is held high for every cycle of a product; the bit counter wraps
// after the last cycle so the next product can follow immediately.
module gf2m_mul #(
    parameter int          M    = 4,
    parameter logic [M-1:0] POLY = M'(4'b0011)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p,
    output logic         done
);

    // Multiply by x and fold the overflow bit back through the polynomial.
    function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
        return (v << 1) ^ (v[M-1] ? POLY : '0);
    endfunction

`ifdef LD_PADD_SERIAL_MUL_EN
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    logic [CW-1:0] cnt_reg;
    logic [M-1:0]  acc_reg;
    logic [M-1:0]  acc_in;
    logic [CW-1:0] bit_idx;

    // One Horner iteration per cycle: acc = acc*x + b[i]*a, i from MSB down.
    always_comb begin
        acc_in  = (cnt_reg == '0) ? '0 : acc_reg;
        bit_idx = CW'(M - 1) - cnt_reg;
        p       = mulx(acc_in) ^ (b[bit_idx] ? a : '0);
        done    = start && (cnt_reg == CW'(M - 1));
    end

    // Accumulator and bit counter; counter wraps to zero on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            acc_reg <= '0;
        end else if (start) begin
            acc_reg <= p;
            cnt_reg <= done ? '0 : cnt_reg + CW'(1);
        end
    end
`else
    logic unused_serial_ports;
    assign unused_serial_ports = ^{clk, rst, start};

    // Fully unrolled Horner evaluation, MSB first.
    always_comb begin
        p = '0;
        for (int i = M - 1; i >= 0; i--) begin
            p = mulx(p) ^ (b[i] ? a : '0);
        end
        done = 1'b1;
    end
`endif

endmodule

// File: rtl/ld_point_add_seq.sv
// Sequential Lopez-Dahab mixed point adder: P0 (projective) + P1 (affine).
// Fourteen multiply steps share one gf2m_mul; additions are fused as XOR
// into the step that consumes them. Handles P0 = infinity (bypass) and
// P0 == P1 (aborts with dbl_req). Build option LD_PADD_SERIAL_MUL_EN selects
// the bit-serial multiplier, stretching every step to M cycles.
module ld_point_add_seq
    import ld_gf2m_pkg::*;
#(
    parameter int           M       = 4,
    parameter logic [M-1:0] POLY    = M'(POLY_DEF),
    parameter logic [M-1:0] CURVE_A = M'(CURVE_A_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] x0,
    input  logic [M-1:0] y0,
    input  logic [M-1:0] z0,
    input  logic [M-1:0] x1,
    input  logic [M-1:0] y1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] x2,
    output logic [M-1:0] y2,
    output logic [M-1:0] z2,
    output logic         dbl_req
);

    state_t       state_reg, state_next;
    step_t        step_reg, step_next;
    logic [M-1:0] x0_reg, y0_reg, z0_reg, x1_reg, y1_reg;
    logic         dbl_req_reg;
    logic         accept, mul_start, mul_done, rf_wr, byp_ld, abort_ld;
    logic [M-1:0] op_a, op_b, addend, prod, wr_data;

    // rf[Sn] holds the value produced by step Sn (T, A, B, C, U, V, D, Z2, E, X2, F, G, W, Y2).
    logic [M-1:0] rf [NUM_STEPS];

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign x2        = rf[S9];
    assign y2        = rf[S13];
    assign z2        = rf[S7];
    assign dbl_req   = dbl_req_reg;
    assign wr_data   = prod ^ addend;

    gf2m_mul #(.M(M), .POLY(POLY)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (op_a),
        .b     (op_b),
        .p     (prod),
        .done  (mul_done)
    );

    // Operand mux: multiplier inputs and fused XOR term for the current step.
    always_comb begin
        op_a   = '0;
        op_b   = '0;
        addend = '0;
        case (step_reg)
            S0:  begin op_a = z0_reg;  op_b = z0_reg;                      end
            S1:  begin op_a = y1_reg;  op_b = rf[S0];  addend = y0_reg;    end
            S2:  begin op_a = x1_reg;  op_b = z0_reg;  addend = x0_reg;    end
            S3:  begin op_a = z0_reg;  op_b = rf[S2];                      end
            S4:  begin op_a = rf[S2];  op_b = rf[S2];                      end
            S5:  begin op_a = CURVE_A; op_b = rf[S0];  addend = rf[S3];    end
            S6:  begin op_a = rf[S4];  op_b = rf[S5];                      end
            S7:  begin op_a = rf[S3];  op_b = rf[S3];                      end
            S8:  begin op_a = rf[S1];  op_b = rf[S3];                      end
            S9:  begin op_a = rf[S1];  op_b = rf[S1];  addend = rf[S6] ^ rf[S8]; end
            S10: begin op_a = x1_reg;  op_b = rf[S7];  addend = rf[S9];    end
            S11: begin op_a = y1_reg;  op_b = rf[S7];  addend = rf[S9];    end
            S12: begin op_a = rf[S8];  op_b = rf[S10];                     end
            S13: begin op_a = rf[S7];  op_b = rf[S11]; addend = rf[S12];   end
            default: ;
        endcase
    end

    // Next-state logic: advance one step per completed product, detect bypass/abort.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        mul_start  = 1'b0;
        rf_wr      = 1'b0;
        byp_ld     = 1'b0;
        abort_ld   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                    step_next  = S0;
                end
            end
            CALC: begin
                mul_start = 1'b1;
                if (mul_done) begin
                    if (z0_reg == '0) begin
                        byp_ld     = 1'b1;
                        state_next = DONE;
                    end else begin
                        rf_wr = 1'b1;
                        if (step_reg == S2 && wr_data == '0 && rf[S1] == '0) begin
                            abort_ld   = 1'b1;
                            state_next = DONE;
                        end else if (step_reg == S13) begin
                            state_next = DONE;
                        end else begin
                            step_next = step_t'(step_reg + 4'd1);
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller state and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            step_reg  <= S0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    // Operand capture on accept; doubling flag set on abort, cleared on new work.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_reg      <= '0;
            y0_reg      <= '0;
            z0_reg      <= '0;
            x1_reg      <= '0;
            y1_reg      <= '0;
            dbl_req_reg <= 1'b0;
        end else begin
            if (accept) begin
                x0_reg      <= x0;
                y0_reg      <= y0;
                z0_reg      <= z0;
                x1_reg      <= x1;
                y1_reg      <= y1;
                dbl_req_reg <= 1'b0;
            end else if (abort_ld) begin
                dbl_req_reg <= 1'b1;
            end
        end
    end

    // Intermediate register file, one word per step. The result words
    // (Z2, X2, Y2) are also loaded by the bypass and zeroed by the abort.
    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_rf
        localparam step_t GSTEP  = step_t'(gi);
        localparam bit    IS_OUT = (GSTEP == S7) || (GSTEP == S9) || (GSTEP == S13);

        logic [M-1:0] r_reg;
        logic [M-1:0] byp_val;

        assign byp_val = (GSTEP == S7) ? M'(1) : (GSTEP == S9) ? x1_reg : y1_reg;
        assign rf[gi]  = r_reg;

        // Step write, or result load on bypass/abort.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_reg <= '0;
            end else if (rf_wr && step_reg == GSTEP) begin
                r_reg <= wr_data;
            end else if (IS_OUT && (byp_ld || abort_ld)) begin
                r_reg <= byp_ld ? byp_val : '0;
            end
        end
    end

endmodule
